// File: rtl/alu_result_mux_pipe.sv
// ---------------------------------------------------------------------------
// alu_result_mux_pipe
//
// NUM_IN-way, WIDTH-bit ALU result selector with a registered output stage
// and a one-entry skid buffer behind a valid/ready handshake. In_ready is
// decoded from the occupancy state only, so there is no combinational path
// from Out_ready back to the ALU side.
//
// Optional build macro: ALU_MUX_ZERO_FLAG_EN
//   When defined, adds output Out_zero (registered with Out, 1 when the
//   selected result is zero, carried through the skid buffer).
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset_n    in   asynchronous active-low reset
//   In_bus     in   NUM_IN*WIDTH flattened inputs, input i = In_bus[i*WIDTH +: WIDTH]
//   Sel        in   SEL_W input index, sampled with In_valid
//   In_valid   in   upstream offers In_bus/Sel
//   In_ready   out  block can accept this cycle (state-decoded)
//   Out        out  WIDTH selected result (registered)
//   Out_valid  out  Out holds a valid result
//   Out_ready  in   downstream accepts Out this cycle
//   Sel_err    out  captured Sel was >= NUM_IN (result forced to 0)
//   Out_zero   out  (ALU_MUX_ZERO_FLAG_EN only) result == 0
// ---------------------------------------------------------------------------
module alu_result_mux_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [NUM_IN*WIDTH-1:0] In_bus,
    input  logic [SEL_W-1:0]        Sel,
    input  logic                    In_valid,
    output logic                    In_ready,
    output logic [WIDTH-1:0]        Out,
    output logic                    Out_valid,
    input  logic                    Out_ready,
    output logic                    Sel_err
`ifdef ALU_MUX_ZERO_FLAG_EN
    ,
    output logic                    Out_zero
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } occ_t;

    occ_t state, state_nxt;

    logic             accept;
    logic             pop;
    logic             load_out_in;
    logic             load_skid;
    logic             load_out_skid;
    logic [WIDTH-1:0] mux_data;
    logic             mux_err;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;

    assign In_ready  = (state != ST_FULL);
    assign Out_valid = (state != ST_EMPTY);
    assign accept    = In_valid && In_ready;
    assign pop       = Out_valid && Out_ready;

    // Out-of-range Sel leaves mux_data at its zero default.
    always_comb begin
        mux_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (Sel == SEL_W'(i)) begin
                mux_data = In_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    // With a power-of-two input count every Sel code is legal.
    generate
        if ((1 << SEL_W) == NUM_IN) begin : g_full_decode
            assign mux_err = 1'b0;
        end else begin : g_partial_decode
            assign mux_err = (int'(Sel) >= NUM_IN);
        end
    endgenerate

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        load_out_in   = 1'b0;
        load_skid     = 1'b0;
        load_out_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt   = ST_ONE;
                    load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    load_out_in = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_nxt     = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Out       <= '0;
            Sel_err   <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else begin
            if (load_out_in) begin
                Out     <= mux_data;
                Sel_err <= mux_err;
            end else if (load_out_skid) begin
                Out     <= skid_data;
                Sel_err <= skid_err;
            end
            if (load_skid) begin
                skid_data <= mux_data;
                skid_err  <= mux_err;
            end
        end
    end

`ifdef ALU_MUX_ZERO_FLAG_EN
    logic mux_zero;
    logic skid_zero;

    // An out-of-range select yields mux_data == 0, so the flag follows.
    assign mux_zero = (mux_data == '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Out_zero  <= 1'b0;
            skid_zero <= 1'b0;
        end else begin
            if (load_out_in) begin
                Out_zero <= mux_zero;
            end else if (load_out_skid) begin
                Out_zero <= skid_zero;
            end
            if (load_skid) begin
                skid_zero <= mux_zero;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_mux_pipe.sv
// Testbench for alu_result_mux_pipe: a 4-input and a 3-input instance driven
// in lockstep, checked against a queue-based occupancy/ordering model.
module tb_alu_result_mux_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } item_t;

    logic         Clk;
    logic         Reset_n;
    logic [127:0] in_bus4;
    logic [95:0]  in_bus3;
    logic [1:0]   sel;
    logic         in_valid;
    logic         out_ready;

    logic         in_ready4, out_valid4, sel_err4;
    logic [31:0]  out4;
    logic         in_ready3, out_valid3, sel_err3;
    logic [31:0]  out3;
`ifdef ALU_MUX_ZERO_FLAG_EN
    logic         zero4, zero3;
`endif

    int unsigned  n_cmp;
    int unsigned  n_err;
    item_t        q4[$];
    item_t        q3[$];

    alu_result_mux_pipe #(.WIDTH(32), .NUM_IN(4)) dut4 (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .In_bus    (in_bus4),
        .Sel       (sel),
        .In_valid  (in_valid),
        .In_ready  (in_ready4),
        .Out       (out4),
        .Out_valid (out_valid4),
        .Out_ready (out_ready),
        .Sel_err   (sel_err4)
`ifdef ALU_MUX_ZERO_FLAG_EN
        ,
        .Out_zero  (zero4)
`endif
    );

    alu_result_mux_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .In_bus    (in_bus3),
        .Sel       (sel),
        .In_valid  (in_valid),
        .In_ready  (in_ready3),
        .Out       (out3),
        .Out_valid (out_valid3),
        .Out_ready (out_ready),
        .Sel_err   (sel_err3)
`ifdef ALU_MUX_ZERO_FLAG_EN
        ,
        .Out_zero  (zero3)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: slice number sel of the bus, or zero with error when out of range.
    function automatic item_t ref_item(input logic [127:0] bus, input logic [1:0] s, input int n);
        item_t it;
        if (int'(s) >= n) begin
            it.d = 32'd0;
            it.e = 1'b1;
        end else begin
            it.d = 32'(bus >> (32 * int'(s)));
            it.e = 1'b0;
        end
        return it;
    endfunction

    task automatic check_outputs();
        check("valid4", out_valid4, q4.size() > 0);
        check("ready4", in_ready4, q4.size() < 2);
        check("valid3", out_valid3, q3.size() > 0);
        check("ready3", in_ready3, q3.size() < 2);
        if (q4.size() > 0) begin
            check("data4", out4, q4[0].d);
            check("err4", sel_err4, q4[0].e);
`ifdef ALU_MUX_ZERO_FLAG_EN
            check("zero4", zero4, q4[0].d == 32'd0);
`endif
        end
        if (q3.size() > 0) begin
            check("data3", out3, q3[0].d);
            check("err3", sel_err3, q3[0].e);
`ifdef ALU_MUX_ZERO_FLAG_EN
            check("zero3", zero3, q3[0].d == 32'd0);
`endif
        end
    endtask

    // One cycle: check outputs at the falling edge, drive new inputs, and
    // advance the model by what the coming rising edge will do.
    task automatic step(input logic v, input logic [1:0] s, input logic [127:0] bus, input logic ordy);
        bit acc4, pop4, acc3, pop3;
        @(negedge Clk);
        check_outputs();
        in_valid  = v;
        sel       = s;
        in_bus4   = bus;
        in_bus3   = bus[95:0];
        out_ready = ordy;
        acc4 = v && (q4.size() < 2);
        pop4 = ordy && (q4.size() > 0);
        acc3 = v && (q3.size() < 2);
        pop3 = ordy && (q3.size() > 0);
        if (pop4) void'(q4.pop_front());
        if (pop3) void'(q3.pop_front());
        if (acc4) q4.push_back(ref_item(bus, s, 4));
        if (acc3) q3.push_back(ref_item(bus, s, 3));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out4"}, out4, 32'd0);
        check({tag, "_valid4"}, out_valid4, 1'b0);
        check({tag, "_err4"}, sel_err4, 1'b0);
        check({tag, "_ready4"}, in_ready4, 1'b1);
        check({tag, "_out3"}, out3, 32'd0);
        check({tag, "_valid3"}, out_valid3, 1'b0);
        check({tag, "_err3"}, sel_err3, 1'b0);
        check({tag, "_ready3"}, in_ready3, 1'b1);
`ifdef ALU_MUX_ZERO_FLAG_EN
        check({tag, "_zero4"}, zero4, 1'b0);
        check({tag, "_zero3"}, zero3, 1'b0);
`endif
    endtask

    initial begin
        logic [127:0] bus;
        int unsigned  valid_cnt;
        int unsigned  rdy_drop;

        n_cmp     = 0;
        n_err     = 0;
        Reset_n   = 1'b0;
        in_valid  = 1'b0;
        sel       = '0;
        in_bus4   = '0;
        in_bus3   = '0;
        out_ready = 1'b0;

        // Power-on reset
        #12;
        check_reset_values("por");
        @(negedge Clk);
        Reset_n = 1'b1;

        // Basic select, full rate
        bus = {32'hDDDD0000, 32'hCCCC0000, 32'hBBBB0000, 32'hAAAA0000};
        step(1'b1, 2'd0, bus, 1'b1);
        step(1'b1, 2'd1, bus, 1'b1);
        check("basic_a", out4, 32'hAAAA0000);
        step(1'b1, 2'd2, bus, 1'b1);
        check("basic_b", out4, 32'hBBBB0000);
        step(1'b1, 2'd3, bus, 1'b1);
        check("basic_c", out4, 32'hCCCC0000);
        step(1'b0, 2'd0, '0, 1'b1);
        check("basic_d", out4, 32'hDDDD0000);
        step(1'b0, 2'd0, '0, 1'b1);

        // Stall into the skid buffer, then drain
        step(1'b1, 2'd0, 128'h1, 1'b0);
        step(1'b1, 2'd0, 128'h2, 1'b0);
        step(1'b0, 2'd0, '0, 1'b0);
        check("stall_ready", in_ready4, 1'b0);
        check("stall_hold", out4, 32'h1);
        step(1'b0, 2'd0, '0, 1'b0);
        check("stall_steady", out4, 32'h1);
        step(1'b0, 2'd0, '0, 1'b1);
        check("drain_first", out4, 32'h1);
        step(1'b0, 2'd0, '0, 1'b1);
        check("drain_second", out4, 32'h2);
        check("drain_ready", in_ready4, 1'b1);
        step(1'b0, 2'd0, '0, 1'b1);

        // Out-of-range select on the 3-input instance
        step(1'b1, 2'd3, '1, 1'b1);
        step(1'b0, 2'd0, '0, 1'b1);
        check("oor_out3", out3, 32'd0);
        check("oor_err3", sel_err3, 1'b1);
        check("oor_out4", out4, 32'hFFFFFFFF);
        check("oor_err4", sel_err4, 1'b0);
`ifdef ALU_MUX_ZERO_FLAG_EN
        check("oor_zero3", zero3, 1'b1);
`endif
        step(1'b0, 2'd0, '0, 1'b1);

        // Reset while output and skid are both occupied
        step(1'b1, 2'd1, {4{32'h5A5A0001}}, 1'b0);
        step(1'b1, 2'd2, {4{32'h5A5A0002}}, 1'b0);
        step(1'b0, 2'd0, '0, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        q4.delete();
        q3.delete();
        @(negedge Clk);
        check_reset_values("midrst_hold");
        Reset_n = 1'b1;
        step(1'b1, 2'd2, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b1);
        step(1'b0, 2'd0, '0, 1'b1);
        check("post_rst_first", out4, 32'h3);
        step(1'b0, 2'd0, '0, 1'b1);

        // Throughput: 100 back-to-back items, downstream always ready
        valid_cnt = 0;
        rdy_drop  = 0;
        for (int i = 0; i < 100; i++) begin
            bus = {$urandom, $urandom, $urandom, $urandom};
            step(1'b1, 2'($urandom_range(0, 3)), bus, 1'b1);
            if (out_valid4 === 1'b1) valid_cnt++;
            if (in_ready4 !== 1'b1) rdy_drop++;
        end
        step(1'b0, 2'd0, '0, 1'b1);
        if (out_valid4 === 1'b1) valid_cnt++;
        check("tput_valid_cycles", valid_cnt, 100);
        check("tput_ready_drops", rdy_drop, 0);
        step(1'b0, 2'd0, '0, 1'b1);

        // Random traffic and back-pressure
        for (int i = 0; i < 10000; i++) begin
            bus = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) bus = '0;
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), bus,
                 $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'd0, '0, 1'b1);
        end
        check("final_empty4", out_valid4, 1'b0);
        check("final_empty3", out_valid3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
